// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter for the async FIFO write port
//
// Shares one FIFO write side among NUM_REQ valid/ready requesters in the
// wr_clk domain. A grant lasts for up to MAX_BURST words. It is never
// pre-empted, and the arbiter never writes while full is high.
//
// Ports:
//   wr_clk       write-domain clock
//   rst_n        synchronous active-low reset
//   req_valid    per-requester word valid
//   req_data     packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester accept (one-hot or zero)
//   full         FIFO full flag
//   overflow     FIFO overflow flag
//   wr_en        FIFO write enable
//   wdata        FIFO write data (0 when idle)
//   grant_id     current grant holder (meaningful while busy)
//   busy         grant active
//   err_overflow sticky overflow seen
//   stall_cnt    saturating count of granted words blocked by full
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    input  logic                          overflow,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          err_overflow,
    output logic [15:0]                   stall_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BW   = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [BW-1:0]   burst_cnt;

    // Returns {found, index} of the first set bit of vec at or after start,
    // wrapping modulo NUM_REQ. Scanning from the far end lets the nearest
    // candidate overwrite earlier hits.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                              input logic [ID_W-1:0]    start);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (vec[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    logic                hold_valid;
    logic                burst_last;
    logic                release_grant;
    logic [ID_W-1:0]     next_ptr;
    logic [NUM_REQ-1:0]  holder_mask;
    logic [NUM_REQ-1:0]  rearb_vec;
    logic [ID_W:0]       idle_pick;
    logic [ID_W:0]       rel_pick;

    assign busy       = (state == GRANT);
    assign hold_valid = req_valid[grant_id];
    assign wr_en      = busy && hold_valid && !full && rst_n;
    assign req_ready  = wr_en ? (NUM_REQ'(1) << grant_id) : '0;
    assign wdata      = busy ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign burst_last    = (burst_cnt == BW'(MAX_BURST - 1));
    assign release_grant = (wr_en && burst_last) || !hold_valid;
    assign next_ptr      = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    assign holder_mask   = NUM_REQ'(1) << grant_id;

    // A holder that dropped valid is excluded from the re-arbitration. A holder
    // released by burst length stays eligible, but the scan starts just past
    // it, so it wins only when nobody else is valid.
    assign rearb_vec = hold_valid ? req_valid : (req_valid & ~holder_mask);
    assign idle_pick = rr_pick(req_valid, rr_ptr);
    assign rel_pick  = rr_pick(rearb_vec, next_ptr);

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant_id     <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            err_overflow <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (overflow) begin
                err_overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (idle_pick[ID_W]) begin
                        state     <= GRANT;
                        grant_id  <= idle_pick[ID_W-1:0];
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                        if (rel_pick[ID_W]) begin
                            grant_id <= rel_pick[ID_W-1:0];
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wr_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (hold_valid && full && stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
